// File: rtl/cam_sensor_emulator.sv
// Parallel-port camera sensor stand-in: PIXCLK = CLK/2 with FRAME_VALID/LINE_VALID/DATA
// timing and blanking that mimic the sensor, plus selectable test patterns.
module cam_sensor_emulator #(
   parameter int H        = 752,
   parameter int V        = 480,
   parameter int H_BLANK  = 94,
   parameter int V_BLANK  = 45,
   parameter int FV_LEAD  = 4,
   parameter int FV_TRAIL = 4
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       ENABLE,
   input  logic [1:0] PATTERN,
   output logic       PIXCLK,
   output logic       FRAME_VALID,
   output logic       LINE_VALID,
   output logic [9:0] DATA,
   output logic [7:0] FRAME_COUNT,
   output logic       BUSY
);

   localparam int VB_TICKS = V_BLANK * (H + H_BLANK);
   localparam int T_MAX0   = (VB_TICKS > FV_LEAD) ? VB_TICKS : FV_LEAD;
   localparam int T_MAX    = (T_MAX0 > FV_TRAIL) ? T_MAX0 : FV_TRAIL;
   localparam int CW       = (H > 1) ? $clog2(H) : 1;
   localparam int LW       = (V > 1) ? $clog2(V) : 1;
   localparam int TW       = $clog2(T_MAX + 1);

   localparam logic [CW-1:0] COL_LAST  = CW'(H - 1);
   localparam logic [LW-1:0] LINE_LAST = LW'(V - 1);
   localparam logic [TW-1:0] LEAD_LAST = TW'(FV_LEAD - 1);
   localparam logic [TW-1:0] HB_LAST   = TW'(H_BLANK - 1);
   localparam logic [TW-1:0] TR_LAST   = TW'(FV_TRAIL - 1);
   localparam logic [TW-1:0] VB_LAST   = TW'(VB_TICKS - 1);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_LEAD   = 3'd1;
   localparam logic [2:0] ST_ACTIVE = 3'd2;
   localparam logic [2:0] ST_HBLANK = 3'd3;
   localparam logic [2:0] ST_TRAIL  = 3'd4;
   localparam logic [2:0] ST_VBLANK = 3'd5;

   logic          ph_r;
   logic [2:0]    state_r, state_s;
   logic [CW-1:0] col_r, col_s, col_inc_s;
   logic [LW-1:0] line_r, line_s, line_inc_s;
   logic [TW-1:0] tmr_r, tmr_s;
   logic [1:0]    pat_r, pat_s;
   logic          fv_r, fv_s;
   logic          lv_r, lv_s;
   logic [9:0]    data_r, data_s;
   logic [7:0]    fc_r, fc_s;
   logic          busy_r;

   function automatic logic [9:0] pixel_value(input logic [1:0] pat, input logic [CW-1:0] col,
                                              input logic [LW-1:0] line, input logic [7:0] fc);
      logic [9:0] c10;
      logic [9:0] l10;
      logic [9:0] v;
      c10 = 10'(col);
      l10 = 10'(line);
      case (pat)
         2'd0:    v = c10;
         2'd1:    v = l10;
         2'd2:    v = (c10[3] ^ l10[3]) ? 10'h3FF : 10'h000;
         2'd3:    v = {fc, 2'b00};
         default: v = 10'h000;
      endcase
      return v;
   endfunction

   assign col_inc_s  = col_r + 1'b1;
   assign line_inc_s = line_r + 1'b1;

   // Next-state and next-output logic; everything holds except on the ph 1->0 tick.
   always_comb begin
      state_s = state_r;
      col_s   = col_r;
      line_s  = line_r;
      tmr_s   = tmr_r;
      pat_s   = pat_r;
      fv_s    = fv_r;
      lv_s    = lv_r;
      data_s  = data_r;
      fc_s    = fc_r;
      if (ph_r) begin
         case (state_r)
            ST_IDLE: begin
               if (ENABLE) begin
                  state_s = ST_LEAD;
                  fv_s    = 1'b1;
                  pat_s   = PATTERN;
                  line_s  = {LW{1'b0}};
                  tmr_s   = {TW{1'b0}};
               end else begin
                  state_s = ST_IDLE;
               end
            end
            ST_LEAD: begin
               if (tmr_r == LEAD_LAST) begin
                  state_s = ST_ACTIVE;
                  lv_s    = 1'b1;
                  col_s   = {CW{1'b0}};
                  data_s  = pixel_value(pat_r, {CW{1'b0}}, line_r, fc_r);
               end else begin
                  tmr_s = tmr_r + 1'b1;
               end
            end
            ST_ACTIVE: begin
               if (col_r == COL_LAST) begin
                  lv_s    = 1'b0;
                  data_s  = 10'h000;
                  tmr_s   = {TW{1'b0}};
                  state_s = (line_r == LINE_LAST) ? ST_TRAIL : ST_HBLANK;
               end else begin
                  col_s  = col_inc_s;
                  data_s = pixel_value(pat_r, col_inc_s, line_r, fc_r);
               end
            end
            ST_HBLANK: begin
               if (tmr_r == HB_LAST) begin
                  state_s = ST_ACTIVE;
                  line_s  = line_inc_s;
                  lv_s    = 1'b1;
                  col_s   = {CW{1'b0}};
                  data_s  = pixel_value(pat_r, {CW{1'b0}}, line_inc_s, fc_r);
               end else begin
                  tmr_s = tmr_r + 1'b1;
               end
            end
            ST_TRAIL: begin
               if (tmr_r == TR_LAST) begin
                  state_s = ST_VBLANK;
                  fv_s    = 1'b0;
                  fc_s    = fc_r + 1'b1;
                  tmr_s   = {TW{1'b0}};
               end else begin
                  tmr_s = tmr_r + 1'b1;
               end
            end
            ST_VBLANK: begin
               // ENABLE only matters here, so a frame in flight always completes.
               if (tmr_r == VB_LAST) begin
                  if (ENABLE) begin
                     state_s = ST_LEAD;
                     fv_s    = 1'b1;
                     pat_s   = PATTERN;
                     line_s  = {LW{1'b0}};
                     tmr_s   = {TW{1'b0}};
                  end else begin
                     state_s = ST_IDLE;
                  end
               end else begin
                  tmr_s = tmr_r + 1'b1;
               end
            end
            default: begin
               state_s = ST_IDLE;
               fv_s    = 1'b0;
               lv_s    = 1'b0;
               data_s  = 10'h000;
            end
         endcase
      end else begin
         state_s = state_r;
      end
   end

   // State and output registers; asynchronous reset aborts any frame in progress.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         ph_r    <= 1'b0;
         state_r <= ST_IDLE;
         col_r   <= {CW{1'b0}};
         line_r  <= {LW{1'b0}};
         tmr_r   <= {TW{1'b0}};
         pat_r   <= 2'd0;
         fv_r    <= 1'b0;
         lv_r    <= 1'b0;
         data_r  <= 10'h000;
         fc_r    <= 8'd0;
         busy_r  <= 1'b0;
      end else begin
         ph_r    <= ~ph_r;
         state_r <= state_s;
         col_r   <= col_s;
         line_r  <= line_s;
         tmr_r   <= tmr_s;
         pat_r   <= pat_s;
         fv_r    <= fv_s;
         lv_r    <= lv_s;
         data_r  <= data_s;
         fc_r    <= fc_s;
         busy_r  <= (state_s != ST_IDLE);
      end
   end

   assign PIXCLK      = ph_r;
   assign FRAME_VALID = fv_r;
   assign LINE_VALID  = lv_r;
   assign DATA        = data_r;
   assign FRAME_COUNT = fc_r;
   assign BUSY        = busy_r;

endmodule

// File: tb/tb_cam_sensor_emulator.sv
// Bench for cam_sensor_emulator: a small 8x4 instance for timing/control scenarios and a
// 16x16 instance for the checkerboard; pixel values are scored from expectation queues.
module tb_cam_sensor_emulator;

   localparam int T_H  = 8;
   localparam int T_HB = 3;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic       ENABLE = 1'b0;
   logic [1:0] PATTERN = 2'd0;
   logic       PIXCLK, FRAME_VALID, LINE_VALID, BUSY;
   logic [9:0] DATA;
   logic [7:0] FRAME_COUNT;

   logic       enable_cb = 1'b0;
   logic [1:0] pattern_cb = 2'd2;
   logic       pixclk_cb, fv_cb, lv_cb, busy_cb;
   logic [9:0] data_cb;
   logic [7:0] fc_cb;

   int checks = 0;
   int failures = 0;
   int exp_fc = 0;
   logic [9:0] exp_q[$];
   logic [9:0] cb_q[$];

   always #5 CLK = ~CLK;

   cam_sensor_emulator #(.H(8), .V(4), .H_BLANK(3), .V_BLANK(2), .FV_LEAD(2), .FV_TRAIL(2)) dut (
      .CLK(CLK), .RST(RST), .ENABLE(ENABLE), .PATTERN(PATTERN), .PIXCLK(PIXCLK),
      .FRAME_VALID(FRAME_VALID), .LINE_VALID(LINE_VALID), .DATA(DATA),
      .FRAME_COUNT(FRAME_COUNT), .BUSY(BUSY));

   cam_sensor_emulator #(.H(16), .V(16), .H_BLANK(3), .V_BLANK(2), .FV_LEAD(2), .FV_TRAIL(2)) dut_cb (
      .CLK(CLK), .RST(RST), .ENABLE(enable_cb), .PATTERN(pattern_cb), .PIXCLK(pixclk_cb),
      .FRAME_VALID(fv_cb), .LINE_VALID(lv_cb), .DATA(data_cb),
      .FRAME_COUNT(fc_cb), .BUSY(busy_cb));

   function automatic logic [9:0] model_pix(input int pat, input int col, input int line, input int fc);
      case (pat)
         0:       return 10'(col);
         1:       return 10'(line);
         2:       return (((col / 8) + (line / 8)) % 2 == 1) ? 10'h3FF : 10'h000;
         3:       return 10'((fc % 256) * 4);
         default: return 10'h000;
      endcase
   endfunction

   task automatic push_frame(input int pat, input int fc, input bit to_cb);
      int h = to_cb ? 16 : 8;
      int v = to_cb ? 16 : 4;
      for (int l = 0; l < v; l++)
         for (int c = 0; c < h; c++)
            if (to_cb) cb_q.push_back(model_pix(pat, c, l, fc));
            else exp_q.push_back(model_pix(pat, c, l, fc));
   endtask

   // One sample per pixel period, mid-way through PIXCLK high.
   task automatic next_sample();
      @(negedge CLK);
      if (PIXCLK !== 1'b1) @(negedge CLK);
   endtask

   task automatic wait_fv(input logic lvl, input int bound, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < bound; i++) begin
         if (FRAME_VALID === lvl) begin
            ok = 1'b1;
            break;
         end
         next_sample();
      end
   endtask

   task automatic wait_idle(input int bound, output int cnt, output bit ok);
      cnt = 0;
      while (BUSY === 1'b1 && cnt < bound) begin
         cnt++;
         next_sample();
      end
      ok = (BUSY === 1'b0);
   endtask

   // Called on the first sample with FRAME_VALID high; returns on the first sample with it low.
   task automatic measure_frame(input int drop_at, output int fv_len, output int pulses,
                                output int bad_len, output int bad_gap, output int lead, output int trail);
      int run_lv = 0;
      int run_gap = 0;
      bit seen = 1'b0;
      fv_len = 0; pulses = 0; bad_len = 0; bad_gap = 0; lead = 0; trail = 0;
      while (FRAME_VALID === 1'b1 && fv_len < 1000) begin
         if (fv_len == drop_at) ENABLE = 1'b0;
         if (LINE_VALID === 1'b1) begin
            if (!seen) lead = run_gap;
            else if (run_gap != 0 && run_gap != T_HB) bad_gap++;
            seen = 1'b1;
            run_gap = 0;
            run_lv++;
         end else begin
            if (run_lv != 0) begin
               pulses++;
               if (run_lv != T_H) bad_len++;
            end
            run_lv = 0;
            run_gap++;
         end
         fv_len++;
         next_sample();
      end
      if (run_lv != 0) begin
         pulses++;
         if (run_lv != T_H) bad_len++;
      end
      trail = run_gap;
   endtask

   // Scoreboard for the 8x4 instance: every LINE_VALID pixel pops one expected value.
   always @(negedge CLK) begin
      if (RST === 1'b1 && PIXCLK === 1'b1) begin
         checks++;
         if (LINE_VALID === 1'b1) begin
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_pixel: got DATA=%h with no expected pixel", DATA);
            end else begin
               logic [9:0] e;
               e = exp_q.pop_front();
               if (DATA !== e) begin
                  failures++;
                  $display("FAIL pixel: got %h expected %h", DATA, e);
               end
            end
         end else if (DATA !== 10'h000) begin
            failures++;
            $display("FAIL data_in_blank: got %h expected 000", DATA);
         end
      end
   end

   // Scoreboard for the 16x16 checkerboard instance.
   always @(negedge CLK) begin
      if (RST === 1'b1 && pixclk_cb === 1'b1) begin
         checks++;
         if (lv_cb === 1'b1) begin
            if (cb_q.size() == 0) begin
               failures++;
               $display("FAIL cb_unexpected_pixel: got DATA=%h with no expected pixel", data_cb);
            end else begin
               logic [9:0] e;
               e = cb_q.pop_front();
               if (data_cb !== e) begin
                  failures++;
                  $display("FAIL cb_pixel: got %h expected %h", data_cb, e);
               end
            end
         end else if (data_cb !== 10'h000) begin
            failures++;
            $display("FAIL cb_data_in_blank: got %h expected 000", data_cb);
         end
      end
   end

   task automatic test_reset();
      RST = 1'b0;
      ENABLE = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      checks++;
      if ({PIXCLK, FRAME_VALID, LINE_VALID, BUSY} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_ctrl: got %b expected 0000", {PIXCLK, FRAME_VALID, LINE_VALID, BUSY});
      end
      checks++;
      if (DATA !== 10'h000 || FRAME_COUNT !== 8'd0) begin
         failures++;
         $display("FAIL reset_data: got DATA=%h FC=%0d expected 0/0", DATA, FRAME_COUNT);
      end
      @(negedge CLK) RST = 1'b1;
      @(posedge CLK);
      #1;
      checks++;
      if (PIXCLK !== 1'b1) begin
         failures++;
         $display("FAIL first_edge_pixclk: got %b expected 1", PIXCLK);
      end
      @(posedge CLK);
      #1;
      checks++;
      if (PIXCLK !== 1'b0 || BUSY !== 1'b0) begin
         failures++;
         $display("FAIL first_tick: got PIXCLK=%b BUSY=%b expected 0/0", PIXCLK, BUSY);
      end
      exp_fc = 0;
   endtask

   task automatic test_single_frame();
      bit ok;
      int fv_len, pulses, bad_len, bad_gap, lead, trail, vb, fv_seen;
      push_frame(0, exp_fc, 1'b0);
      PATTERN = 2'd0;
      ENABLE = 1'b1;
      wait_fv(1'b1, 10, ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL single_fv_rise: got timeout expected FRAME_VALID rise");
      end
      measure_frame(0, fv_len, pulses, bad_len, bad_gap, lead, trail);
      checks++;
      if (fv_len != 45) begin
         failures++;
         $display("FAIL single_fv_len: got %0d expected 45", fv_len);
      end
      checks++;
      if (pulses != 4 || bad_len != 0 || bad_gap != 0) begin
         failures++;
         $display("FAIL single_lines: got pulses=%0d bad_len=%0d bad_gap=%0d expected 4/0/0", pulses, bad_len, bad_gap);
      end
      checks++;
      if (lead != 2 || trail != 2) begin
         failures++;
         $display("FAIL single_lead_trail: got %0d/%0d expected 2/2", lead, trail);
      end
      checks++;
      if (FRAME_COUNT !== 8'(exp_fc + 1)) begin
         failures++;
         $display("FAIL single_fc: got %0d expected %0d", FRAME_COUNT, exp_fc + 1);
      end
      exp_fc++;
      wait_idle(100, vb, ok);
      checks++;
      if (!ok || vb != 22) begin
         failures++;
         $display("FAIL single_vblank: got %0d ticks ok=%0d expected 22", vb, ok);
      end
      fv_seen = 0;
      for (int i = 0; i < 100; i++) begin
         if (FRAME_VALID !== 1'b0 || BUSY !== 1'b0) fv_seen++;
         next_sample();
      end
      checks++;
      if (fv_seen != 0) begin
         failures++;
         $display("FAIL single_stays_idle: got %0d active samples expected 0", fv_seen);
      end
   endtask

   task automatic test_back_to_back();
      bit ok, fell;
      int period, busy_bad, fv_len, pulses, bad_len, bad_gap, lead, trail, vb;
      push_frame(0, exp_fc, 1'b0);
      push_frame(0, exp_fc + 1, 1'b0);
      PATTERN = 2'd0;
      ENABLE = 1'b1;
      wait_fv(1'b1, 10, ok);
      period = 0;
      fell = 1'b0;
      busy_bad = 0;
      while (period < 200) begin
         next_sample();
         period++;
         if (BUSY !== 1'b1) busy_bad++;
         if (!fell && FRAME_VALID === 1'b0) begin
            fell = 1'b1;
            checks++;
            if (FRAME_COUNT !== 8'(exp_fc + 1)) begin
               failures++;
               $display("FAIL b2b_fc_first: got %0d expected %0d", FRAME_COUNT, exp_fc + 1);
            end
         end else if (fell && FRAME_VALID === 1'b1) begin
            break;
         end
      end
      exp_fc++;
      checks++;
      if (!ok || period != 67) begin
         failures++;
         $display("FAIL b2b_period: got %0d ticks expected 67", period);
      end
      checks++;
      if (busy_bad != 0) begin
         failures++;
         $display("FAIL b2b_busy: got %0d low samples expected 0", busy_bad);
      end
      measure_frame(0, fv_len, pulses, bad_len, bad_gap, lead, trail);
      checks++;
      if (fv_len != 45 || FRAME_COUNT !== 8'(exp_fc + 1)) begin
         failures++;
         $display("FAIL b2b_second: got len=%0d FC=%0d expected 45/%0d", fv_len, FRAME_COUNT, exp_fc + 1);
      end
      exp_fc++;
      wait_idle(100, vb, ok);
   endtask

   task automatic test_pattern_switch();
      bit ok1, ok2, ok3, ok4;
      int vb;
      push_frame(1, exp_fc, 1'b0);
      push_frame(0, exp_fc + 1, 1'b0);
      PATTERN = 2'd1;
      ENABLE = 1'b1;
      wait_fv(1'b1, 10, ok1);
      repeat (20) next_sample();
      PATTERN = 2'd0;
      wait_fv(1'b0, 100, ok2);
      wait_fv(1'b1, 40, ok3);
      ENABLE = 1'b0;
      next_sample();
      wait_fv(1'b0, 100, ok4);
      wait_idle(100, vb, ok4);
      checks++;
      if (!(ok1 && ok2 && ok3 && ok4) || exp_q.size() != 0) begin
         failures++;
         $display("FAIL pattern_switch: got ok=%b%b%b%b left=%0d expected 1111/0", ok1, ok2, ok3, ok4, exp_q.size());
      end
      checks++;
      if (FRAME_COUNT !== 8'(exp_fc + 2)) begin
         failures++;
         $display("FAIL pattern_switch_fc: got %0d expected %0d", FRAME_COUNT, exp_fc + 2);
      end
      exp_fc += 2;
   endtask

   task automatic test_enable_drop();
      bit ok;
      int fv_len, pulses, bad_len, bad_gap, lead, trail, vb, act;
      push_frame(0, exp_fc, 1'b0);
      ENABLE = 1'b1;
      wait_fv(1'b1, 10, ok);
      measure_frame(15, fv_len, pulses, bad_len, bad_gap, lead, trail);
      checks++;
      if (!ok || fv_len != 45 || pulses != 4) begin
         failures++;
         $display("FAIL drop_frame: got len=%0d pulses=%0d expected 45/4", fv_len, pulses);
      end
      wait_idle(100, vb, ok);
      checks++;
      if (!ok || vb != 22) begin
         failures++;
         $display("FAIL drop_vblank: got %0d ticks expected 22", vb);
      end
      exp_fc++;
      act = 0;
      for (int i = 0; i < 150; i++) begin
         if (FRAME_VALID !== 1'b0 || BUSY !== 1'b0) act++;
         next_sample();
      end
      checks++;
      if (act != 0) begin
         failures++;
         $display("FAIL drop_no_restart: got %0d active samples expected 0", act);
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      int fv_len, pulses, bad_len, bad_gap, lead, trail, vb;
      push_frame(3, exp_fc, 1'b0);
      PATTERN = 2'd3;
      ENABLE = 1'b1;
      wait_fv(1'b1, 10, ok);
      repeat (5) next_sample();
      checks++;
      if (LINE_VALID !== 1'b1) begin
         failures++;
         $display("FAIL mid_line_precondition: got LV=%b expected 1", LINE_VALID);
      end
      #2 RST = 1'b0;
      #1;
      checks++;
      if ({PIXCLK, FRAME_VALID, LINE_VALID, BUSY} !== 4'b0000 || DATA !== 10'h000 || FRAME_COUNT !== 8'd0) begin
         failures++;
         $display("FAIL async_reset: got ctrl=%b DATA=%h FC=%0d expected 0", {PIXCLK, FRAME_VALID, LINE_VALID, BUSY}, DATA, FRAME_COUNT);
      end
      exp_q.delete();
      exp_fc = 0;
      push_frame(3, 0, 1'b0);
      push_frame(3, 1, 1'b0);
      repeat (4) @(posedge CLK);
      @(negedge CLK) RST = 1'b1;
      wait_fv(1'b1, 10, ok);
      measure_frame(-1, fv_len, pulses, bad_len, bad_gap, lead, trail);
      checks++;
      if (!ok || fv_len != 45 || pulses != 4 || FRAME_COUNT !== 8'd1) begin
         failures++;
         $display("FAIL post_reset_frame0: got len=%0d pulses=%0d FC=%0d expected 45/4/1", fv_len, pulses, FRAME_COUNT);
      end
      wait_fv(1'b1, 40, ok);
      ENABLE = 1'b0;
      measure_frame(-1, fv_len, pulses, bad_len, bad_gap, lead, trail);
      checks++;
      if (!ok || fv_len != 45 || FRAME_COUNT !== 8'd2) begin
         failures++;
         $display("FAIL post_reset_frame1: got len=%0d FC=%0d expected 45/2", fv_len, FRAME_COUNT);
      end
      exp_fc = 2;
      wait_idle(100, vb, ok);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL post_reset_leftover: got %0d pixels expected 0", exp_q.size());
      end
   endtask

   task automatic test_checkerboard();
      bit ok = 1'b0;
      int n = 0;
      push_frame(2, 0, 1'b1);
      enable_cb = 1'b1;
      for (int i = 0; i < 20 && !ok; i++) begin
         if (fv_cb === 1'b1) ok = 1'b1;
         else next_sample();
      end
      enable_cb = 1'b0;
      while (busy_cb !== 1'b0 && n < 800) begin
         n++;
         next_sample();
      end
      checks++;
      if (!ok || busy_cb !== 1'b0 || cb_q.size() != 0) begin
         failures++;
         $display("FAIL checkerboard: got start=%0d busy=%b left=%0d expected 1/0/0", ok, busy_cb, cb_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_pattern_switch();
      test_enable_drop();
      test_checkerboard();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cam_sensor_emulator.md
# cam_sensor_emulator

Synthesizable stand-in for the MT9V034 parallel output port: generates PIXCLK, FRAME_VALID, LINE_VALID and 10-bit DATA with sensor-like frame/line blanking and selectable test patterns. It drives the camera capture block in place of the real sensor, for bring-up and hardware-in-the-loop testing of the capture, line-buffer and UART frame-dump path. It is the transmitter end of the sensor pixel interface.

## Interface
- H, 752: active pixels per line
- V, 480: active lines per frame
- H_BLANK, 94: LINE_VALID-low pixel periods between lines (≥1)
- V_BLANK, 45: vertical blanking, in line periods of (H+H_BLANK) pixel periods (≥1)
- FV_LEAD, 4: pixel periods from FRAME_VALID rise to first LINE_VALID rise (≥1)
- FV_TRAIL, 4: pixel periods from last LINE_VALID fall to FRAME_VALID fall (≥1)
- CLK  in  1  system clock; sole clock domain
- RST  in  1  asynchronous, active-low reset
- ENABLE  in  1  stream frames while high; sampled only at frame boundaries
- PATTERN  in  2  0 column ramp, 1 line ramp, 2 checkerboard, 3 frame counter
- PIXCLK  out  1  pixel clock, CLK/2, registered
- FRAME_VALID  out  1  high for whole frame incl. lead/trail
- LINE_VALID  out  1  high for H pixel periods per active line
- DATA  out  10  pixel value; 0 whenever LINE_VALID is low
- FRAME_COUNT  out  8  completed frames, wraps 255→0
- BUSY  out  1  high in any state other than IDLE

## Operation
- Phase register ph toggles every CLK; PIXCLK = ph. "Tick" = CLK edge where ph goes 1→0. FRAME_VALID, LINE_VALID, DATA, counters and state change only on ticks, so they are stable at the following PIXCLK rising edge (consumer samples there).
- States: IDLE, LEAD, ACTIVE, HBLANK, TRAIL, VBLANK.
- IDLE: all video outputs 0. Tick with ENABLE=1 → LEAD, FRAME_VALID←1, PATTERN latched for the frame, line←0.
- LEAD: FV_LEAD ticks, then → ACTIVE (LINE_VALID←1, column←0).
- ACTIVE: H ticks with LINE_VALID=1, column 0..H-1. After column H-1: if line<V-1 → HBLANK, else → TRAIL; LINE_VALID←0, DATA←0.
- HBLANK: H_BLANK ticks, then line+1, → ACTIVE.
- TRAIL: FV_TRAIL ticks, then FRAME_VALID←0, FRAME_COUNT+1, → VBLANK.
- VBLANK: V_BLANK·(H+H_BLANK) ticks; then ENABLE=1 → LEAD (new frame, same edge as FV rise), else → IDLE.
- ENABLE falling mid-frame never truncates a frame; generation stops only at end of VBLANK.
- Patterns (column/line of the current pixel): 0 → column[9:0]; 1 → line[9:0]; 2 → (column[3]^line[3]) ? 10'h3FF : 10'h000; 3 → {FRAME_COUNT,2'b00} (count at frame start).
- Counters: column width $clog2(H), line width $clog2(V), blank counter wide enough for V_BLANK·(H+H_BLANK); zero-extend into DATA.

## Timing
- Reset (RST low, asynchronous): ph=0, PIXCLK=0, FRAME_VALID=0, LINE_VALID=0, DATA=0, FRAME_COUNT=0, BUSY=0, state IDLE. Reset mid-frame aborts immediately; no partial-frame recovery.
- First tick after reset release: second CLK edge (ph 0→1, then 1→0).
- Latency ENABLE→FRAME_VALID: FRAME_VALID rises on the first tick at which ENABLE is sampled 1 in IDLE.
- FRAME_VALID high duration: FV_LEAD + V·H + (V-1)·H_BLANK + FV_TRAIL ticks.
- Frame period (continuous ENABLE): above + V_BLANK·(H+H_BLANK) ticks; each tick = 2 CLK.
- LINE_VALID and DATA transition on the same tick; DATA never nonzero with LINE_VALID low.
- FRAME_COUNT updates on the FRAME_VALID falling tick; 255 wraps to 0.

## Test plan
All with H=8, V=4, H_BLANK=3, V_BLANK=2, FV_LEAD=2, FV_TRAIL=2.
- Reset then ENABLE=1, PATTERN=0 → FV high 45 ticks (90 CLK); 4 LV pulses of 8 ticks, 3-tick gaps; DATA per line 0,1,..,7.
- ENABLE held high → FV rising edges 67 ticks (134 CLK) apart; FRAME_COUNT 0→1→2 at each FV fall; BUSY stays 1.
- PATTERN=2 with H=16, V=16 → DATA 0 for columns 0–7 on lines 0–7, 0x3FF for columns 8–15 on lines 0–7, inverse on lines 8–15.
- PATTERN=1 changed to 0 mid-frame → current frame keeps line ramp (0,1,2,3); next frame shows column ramp.
- ENABLE dropped during line 1 → frame completes (all 4 lines), VBLANK completes, then IDLE, BUSY=0, no further FV.
- RST asserted mid-line → all outputs 0 asynchronously; after release with ENABLE=1, full clean frame from line 0, FRAME_COUNT restarts at 0; PATTERN=3 shows DATA=0 in frame 0, 4 in frame 1.
